// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error strobe.
// Optional parity bit checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int BIT_PERIOD  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int TW          = $clog2(BIT_PERIOD);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_PERIOD - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_e;
`endif

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          rx_meta_q;
  logic          rx_s_q;
  logic [7:0]    data_out_q;
  logic          data_valid_q;
  logic          busy_q;
  logic          frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic          par_bit_q;
  logic          parity_err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            timer_q <= '0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        // Re-check the line half a bit in so short glitches are not taken as frames.
        START: begin
          if (timer_q == HALF_LAST) begin
            if (!rx_s_q) begin
              timer_q   <= '0;
              bit_cnt_q <= '0;
              state_q   <= DATA;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DATA: begin
          if (timer_q == BIT_LAST) begin
            shift_q   <= {rx_s_q, shift_q[7:1]};
            timer_q   <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer_q == BIT_LAST) begin
            par_bit_q <= rx_s_q;
            timer_q   <= '0;
            state_q   <= STOP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
`endif
        STOP: begin
          if (timer_q == BIT_LAST) begin
            timer_q <= '0;
            if (rx_s_q) begin
              data_out_q   <= shift_q;
              data_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= ((^shift_q) ^ par_bit_q) != PARITY_ODD;
`endif
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK_WAIT;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        // Stay busy until the line returns high so a held break yields one error only.
        BREAK_WAIT: begin
          if (rx_s_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver, 8N1 framing, LSB first, idle-high line, matching the team's UART transmitter on the same link. Synchronises the rx pin, detects the start edge, and samples each bit at mid-period using a per-bit clock counter. Delivers each received byte with a one-cycle valid strobe plus a framing-error indication. Sits between the pad and the command-decode logic.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s
BIT_PERIOD, CLK_FREQ/BAUD_RATE (localparam), clocks per bit; HALF_PERIOD = BIT_PERIOD/2 (localparam)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
rx  input  1  serial line, asynchronous to clk, idle high
data_out  output  8  last correctly framed byte
data_valid  output  1  one-cycle strobe: data_out updated this cycle
busy  output  1  frame reception in progress
frame_err  output  1  one-cycle strobe: stop bit sampled low
parity_err  output  1  one-cycle strobe: parity mismatch (macro only, else 0)

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk. All state on posedge clk.
- Reset values: data_out=0, data_valid=0, busy=0, frame_err=0, parity_err=0; both synchroniser flops=1; state=IDLE; timer=0; bit count=0.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s (2-cycle input latency).
- Timer width $clog2(BIT_PERIOD); bit counter 4 bits.
- IDLE: busy=0. On rx_s==0: timer<=0, state<=START, busy<=1.
- START: timer counts up. At timer==HALF_PERIOD-1, sample rx_s:
  - 0: valid start; timer<=0, bit count<=0, state<=DATA.
  - 1: glitch; state<=IDLE, busy<=0, no strobes.
- DATA: at timer==BIT_PERIOD-1, shift rx_s into shift_reg MSB (shift right), timer<=0, bit count+1. After the 8th bit: state<=STOP (or PARITY with macro).
- STOP: at timer==BIT_PERIOD-1, sample rx_s:
  - 1: data_out<=shift_reg, data_valid<=1 for one cycle, state<=IDLE, busy<=0.
  - 0: frame_err<=1 for one cycle, data_out unchanged, no data_valid, state<=BREAK_WAIT.
- BREAK_WAIT: busy=1. Leaves for IDLE on the first cycle rx_s==1. A held-low line (break) does not produce repeated frames.
- Strobes are registered, high exactly one cycle, never both data_valid and frame_err in the same cycle.
- Back-to-back frames: after STOP->IDLE, a start edge is detected on the next cycle; no idle gap is required.
- Reset mid-frame: immediate return to reset values; the partial byte is discarded, no strobe.
- Sampling is mid-bit, referenced to the first cycle rx_s is seen low. Tolerance is about ±4% total baud mismatch.

Optional Feature:
Macro UART_RX_PARITY_EN. When defined: extra parameter PARITY_ODD (default 0 = even). A PARITY state follows DATA and samples the bit at timer==BIT_PERIOD-1. At a good stop bit, data_valid pulses and data_out updates as usual. parity_err pulses in the same cycle if the XOR of the 8 data bits and the parity bit does not equal PARITY_ODD. A framing error suppresses parity_err. When undefined: there is no PARITY state, the frame is 10 bits, and parity_err is tied 0.

Test Plan:
Use CLK_FREQ=1000 and BAUD_RATE=100 (BIT_PERIOD=10, HALF=5).
1. Send 0xA5 8N1 -> exactly one data_valid pulse with data_out=0xA5, frame_err=0; busy high during the frame, 0 after the STOP sample.
2. rx low for 3 clocks then high -> busy pulses briefly, returns to IDLE; no data_valid, no frame_err; data_out unchanged.
3. Send 0x3C with stop bit 0 and rx held low for 30 clocks -> one frame_err pulse, no data_valid, data_out keeps 0xA5, busy held until rx high. Then send 0x55 -> data_valid with 0x55.
4. Send 0x00 then 0xFF back-to-back with zero idle gap -> two data_valid pulses, 0x00 then 0xFF, no frame_err.
5. Assert reset during bit 4 of 0x81 -> all outputs return to reset values at once, no strobe. Send 0x81 after release -> data_valid with 0x81.
6. With UART_RX_PARITY_EN and even parity, send 0x07 with parity bit 0 -> data_valid=1 and parity_err=1 in the same cycle, data_out=0x07. Send 0x07 with parity bit 1 -> parity_err=0.
